// File: rtl/serial_rx.sv
// serial_rx: receive end of the serial framing link; mirror of serial_tx.
// Hunts for SOF at any bit alignment, deserializes 32-bit words LSB
// first, holds one word back to learn whether it is the last of the
// frame, then pushes {eof_flag, data[31:0]} into the async FIFO.
//
// Ports:
//   wclk         in   clock; one line bit sampled per rising edge
//   wrst         in   asynchronous active-high reset
//   s_in         in   serial line, idle 0, LSB first
//   wfull        in   FIFO full; checked on the write-decision edge
//   ovf_clr      in   clears the sticky overflow flag
//   wdata[32:0]  out  [32] last word of frame, [31:0] payload
//   winc         out  one-cycle FIFO write strobe, wdata valid with it
//   frame_active out  high while in DATA state
//   overflow     out  sticky; a word was dropped because wfull was high
// Optional (macro RX_STATS_EN):
//   frame_cnt[15:0] out  EOF detections in DATA, empty frames included
//   word_cnt[15:0]  out  successful FIFO writes
module serial_rx #(
    parameter logic [31:0] SOF_PAT = 32'h5a5a5a5a,
    parameter logic [31:0] EOF_PAT = 32'h0f0f0f0f
) (
    input  logic        wclk,
    input  logic        wrst,
    input  logic        s_in,
    input  logic        wfull,
    input  logic        ovf_clr,
    output logic [32:0] wdata,
    output logic        winc,
    output logic        frame_active,
    output logic        overflow
`ifdef RX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] word_cnt
`endif
);

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [32:0] wdata_q, wdata_d;
    logic        winc_q, winc_d;
    logic        overflow_q, overflow_d;
    logic        frame_active_q, frame_active_d;

    logic [31:0] nxt;
    logic        do_write;
    logic [32:0] wr_word;
    logic        eof_hit;

    assign nxt = {s_in, shreg_q[31:1]};

    always_comb begin
        state_d      = state_q;
        shreg_d      = nxt;
        bit_cnt_d    = bit_cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        wdata_d      = wdata_q;
        winc_d       = 1'b0;
        overflow_d   = ovf_clr ? 1'b0 : overflow_q;
        do_write     = 1'b0;
        wr_word      = 33'd0;
        eof_hit      = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (nxt == SOF_PAT) begin
                    state_d   = DATA;
                    bit_cnt_d = 5'd0;
                end
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    if (nxt == EOF_PAT) begin
                        eof_hit      = 1'b1;
                        do_write     = pend_valid_q;
                        wr_word      = {1'b1, pend_q};
                        pend_valid_d = 1'b0;
                        // stale frame bits must not combine into a false SOF
                        shreg_d      = 32'd0;
                        state_d      = HUNT;
                    end else begin
                        do_write     = pend_valid_q;
                        wr_word      = {1'b0, pend_q};
                        pend_d       = nxt;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // setting overflow wins over a same-cycle clear
        if (do_write) begin
            if (!wfull) begin
                winc_d  = 1'b1;
                wdata_d = wr_word;
            end else begin
                overflow_d = 1'b1;
            end
        end

        frame_active_d = (state_d == DATA);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q        <= HUNT;
            shreg_q        <= 32'd0;
            bit_cnt_q      <= 5'd0;
            pend_q         <= 32'd0;
            pend_valid_q   <= 1'b0;
            wdata_q        <= 33'd0;
            winc_q         <= 1'b0;
            overflow_q     <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
            wdata_q        <= wdata_d;
            winc_q         <= winc_d;
            overflow_q     <= overflow_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign wdata        = wdata_q;
    assign winc         = winc_q;
    assign overflow     = overflow_q;
    assign frame_active = frame_active_q;

`ifdef RX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] word_cnt_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            frame_cnt_q <= 16'd0;
            word_cnt_q  <= 16'd0;
        end else begin
            if (eof_hit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (winc_d) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign word_cnt  = word_cnt_q;
`else
    // no statistics counters in this build; eof_hit only feeds them
    logic unused_eof_hit;
    assign unused_eof_hit = eof_hit;
`endif

endmodule
